// File: rtl/booth_mult_param_if.sv
// Handshake/data bundle for booth_mult_param: operand loading, product output and status.
interface booth_mult_param_if #(
  parameter int N = 6
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] inBus;
  logic [N-1:0] outBus;
  logic         done;
  logic         busy;

  modport master (
    output start, signed_mode, inBus,
    input  outBus, done, busy
  );

  modport slave (
    input  start, signed_mode, inBus,
    output outBus, done, busy
  );
endinterface

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier: loads X then Y over inBus, runs N+1 Booth steps,
// then presents the 2N-bit product as high half (with done) followed by low half.
module booth_mult_param #(
  parameter int N = 6
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_param_if.slave bus
);

  localparam int OW = N + 1;            // extended operand width
  localparam int AW = N + 2;            // accumulator width, wide enough for -X of the most-negative operand
  localparam int CW = $clog2(N + 2);
  localparam int SW = AW + OW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    CALC,
    OUT_HI,
    OUT_LO
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic signed [OW-1:0]  x_q, x_d;
  logic        [OW-1:0]  q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic signed [AW-1:0]  a_q, a_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic        [N-1:0]   out_q, out_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic        [SW-1:0]  step;
  logic signed [AW-1:0]  a_nxt;
  logic        [OW-1:0]  q_nxt;

  function automatic logic [OW-1:0] extend(input logic [N-1:0] v, input logic sgn);
    return {sgn & v[N-1], v};
  endfunction

  // One Booth step: add/subtract per (q0, q-1), then arithmetic shift of {A,Q,q-1}.
  // Result packs {A', Q', q-1'} with q-1' in bit 0.
  function automatic logic [SW-1:0] booth_step(
    input logic signed [AW-1:0] a,
    input logic        [OW-1:0] q,
    input logic                 qm1,
    input logic signed [OW-1:0] x
  );
    logic signed [AW-1:0] xe;
    logic signed [AW-1:0] sum;
    xe = {x[OW-1], x};
    case ({q[0], qm1})
      2'b10:   sum = a - xe;
      2'b01:   sum = a + xe;
      default: sum = a;
    endcase
    return {sum[AW-1], sum, q};
  endfunction

  always_comb begin
    step  = booth_step(a_q, q_q, qm1_q, x_q);
    a_nxt = step[SW-1 -: AW];
    q_nxt = step[OW:1];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.signed_mode;
          state_d = LOAD_X;
        end
      end
      LOAD_X: begin
        x_d     = extend(bus.inBus, mode_q);
        state_d = LOAD_Y;
      end
      LOAD_Y: begin
        q_d     = extend(bus.inBus, mode_q);
        qm1_d   = 1'b0;
        a_d     = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = step[0];
        cnt_d = cnt_q + 1'b1;
        // Last step: product bits 2N-1..N straddle A and the top bit of Q.
        if (cnt_q == CW'(N)) begin
          state_d = OUT_HI;
          out_d   = {a_nxt[N-2:0], q_nxt[N]};
          done_d  = 1'b1;
        end
      end
      OUT_HI: begin
        out_d   = q_q[N-1:0];
        state_d = OUT_LO;
      end
      OUT_LO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      x_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      a_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.outBus = out_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_booth_mult_param.sv
// Scoreboard bench for booth_mult_param: N=6 and N=8 instances driven with directed vectors.
module tb_booth_mult_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mult_param_if #(.N(6)) b6 ();
  booth_mult_param_if #(.N(8)) b8 ();

  booth_mult_param #(.N(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));
  booth_mult_param #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  logic        st [2];
  logic        md [2];
  logic [31:0] din [2];

  assign b6.start       = st[0];
  assign b6.signed_mode = md[0];
  assign b6.inBus       = din[0][5:0];
  assign b8.start       = st[1];
  assign b8.signed_mode = md[1];
  assign b8.inBus       = din[1][7:0];

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          c0;
  } exp_t;

  typedef struct {
    bit          m;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t sb6 [$];
  exp_t sb8 [$];

  int cnt_cmp  = 0;
  int cnt_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic busy_of(input int k);
    return (k == 1) ? b8.busy : b6.busy;
  endfunction

  function automatic logic done_of(input int k);
    return (k == 1) ? b8.done : b6.done;
  endfunction

  function automatic logic [31:0] out_of(input int k);
    return (k == 1) ? 32'(b8.outBus) : 32'(b6.outBus);
  endfunction

  // Monitors: pop expected product on done, check high half and latency, then low half.
  bit          lo6 = 1'b0;
  logic [31:0] lo_exp6;
  exp_t        e6;
  always @(negedge clk) begin
    if (lo6) begin
      chk("lo6", 32'(b6.outBus), lo_exp6);
      chk("lo6_done", 32'(b6.done), 32'd0);
      lo6 = 1'b0;
    end else if (b6.done === 1'b1) begin
      if (sb6.size() == 0) begin
        cnt_cmp++;
        cnt_fail++;
        $display("FAIL done6_unexpected: done=1 at cycle %0d, expected done=0 (nothing pending)", cyc);
      end else begin
        e6 = sb6.pop_front();
        chk("hi6", 32'(b6.outBus), e6.hi);
        chk("lat6", 32'(cyc - e6.c0), 32'd9);
        lo_exp6 = e6.lo;
        lo6 = 1'b1;
      end
    end
  end

  bit          lo8 = 1'b0;
  logic [31:0] lo_exp8;
  exp_t        e8;
  always @(negedge clk) begin
    if (lo8) begin
      chk("lo8", 32'(b8.outBus), lo_exp8);
      chk("lo8_done", 32'(b8.done), 32'd0);
      lo8 = 1'b0;
    end else if (b8.done === 1'b1) begin
      if (sb8.size() == 0) begin
        cnt_cmp++;
        cnt_fail++;
        $display("FAIL done8_unexpected: done=1 at cycle %0d, expected done=0 (nothing pending)", cyc);
      end else begin
        e8 = sb8.pop_front();
        chk("hi8", 32'(b8.outBus), e8.hi);
        chk("lat8", 32'(cyc - e8.c0), 32'd11);
        lo_exp8 = e8.lo;
        lo8 = 1'b1;
      end
    end
  end

  // Issues one operation; during CALC it flips signed_mode and pulses start, which must be ignored.
  task automatic run_op(input int k, input bit push, input bit mode,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input bit hold, input bit started);
    int   c0;
    exp_t e;
    if (!started) @(negedge clk);
    st[k] = 1'b1;
    md[k] = mode;
    @(posedge clk);
    #1 c0 = cyc;
    chk("busy_after_start", 32'(busy_of(k)), 32'd1);
    @(negedge clk);
    if (!hold) st[k] = 1'b0;
    din[k] = x;
    @(posedge clk);
    @(negedge clk);
    din[k] = y;
    @(posedge clk);
    if (push) begin
      e.hi = hi;
      e.lo = lo;
      e.c0 = c0;
      if (k == 1) sb8.push_back(e);
      else        sb6.push_back(e);
    end
    @(negedge clk);
    md[k]  = ~mode;
    din[k] = $urandom;
    if (!hold) st[k] = 1'b1;
    @(negedge clk);
    if (!hold) st[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_of(k) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_busy", 32'(busy_of(k)), 32'd0);
    chk("idle_out", out_of(k), 32'd0);
    chk("idle_done", 32'(done_of(k)), 32'd0);
  endtask

  vec_t v6 [10];
  vec_t v8 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    v6 = '{
      '{1'b1, 32'h17, 32'h35, 32'h3C, 32'h03},
      '{1'b1, 32'h09, 32'h08, 32'h01, 32'h08},
      '{1'b1, 32'h36, 32'h2D, 32'h02, 32'h3E},
      '{1'b1, 32'h14, 32'h00, 32'h00, 32'h00},
      '{1'b0, 32'h3F, 32'h3F, 32'h3E, 32'h01},
      '{1'b1, 32'h3F, 32'h3F, 32'h00, 32'h01},
      '{1'b1, 32'h20, 32'h20, 32'h10, 32'h00},
      '{1'b0, 32'h2A, 32'h03, 32'h01, 32'h3E},
      '{1'b1, 32'h1F, 32'h20, 32'h30, 32'h20},
      '{1'b0, 32'h36, 32'h05, 32'h04, 32'h0E}
    };
    v8 = '{
      '{1'b0, 32'hFF, 32'hFF, 32'hFE, 32'h01},
      '{1'b1, 32'h80, 32'h80, 32'h40, 32'h00},
      '{1'b1, 32'hFF, 32'h7F, 32'hFF, 32'h81},
      '{1'b0, 32'hFF, 32'h7F, 32'h7E, 32'h81}
    };
    for (int k = 0; k < 2; k++) begin
      st[k]  = 1'b0;
      md[k]  = 1'b0;
      din[k] = '0;
    end

    // Reset state, with start asserted to show reset wins.
    rst   = 1'b1;
    st[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy6", 32'(b6.busy), 32'd0);
    chk("rst_done6", 32'(b6.done), 32'd0);
    chk("rst_out6", 32'(b6.outBus), 32'd0);
    chk("rst_busy8", 32'(b8.busy), 32'd0);
    st[0] = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk("post_rst_busy6", 32'(b6.busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(0, 1'b1, v6[i].m, v6[i].x, v6[i].y, v6[i].hi, v6[i].lo, 1'b0, 1'b0);
      wait_idle(0);
    end

    // start held high: second operation begins one cycle after IDLE is re-entered.
    run_op(0, 1'b1, 1'b1, 32'h17, 32'h35, 32'h3C, 32'h03, 1'b1, 1'b0);
    wait_idle(0);
    run_op(0, 1'b1, 1'b0, 32'h3F, 32'h3F, 32'h3E, 32'h01, 1'b0, 1'b1);
    wait_idle(0);

    // Abort in the third CALC cycle; no done must follow.
    @(negedge clk);
    st[0] = 1'b1;
    md[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0]  = 1'b0;
    din[0] = 32'h17;
    @(posedge clk);
    @(negedge clk);
    din[0] = 32'h35;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(b6.busy), 32'd0);
    chk("abort_done", 32'(b6.done), 32'd0);
    chk("abort_out", 32'(b6.outBus), 32'd0);
    repeat (12) @(negedge clk);
    run_op(0, 1'b1, 1'b1, 32'h17, 32'h35, 32'h3C, 32'h03, 1'b0, 1'b0);
    wait_idle(0);

    for (int i = 0; i < 4; i++) begin
      run_op(1, 1'b1, v8[i].m, v8[i].x, v8[i].y, v8[i].hi, v8[i].lo, 1'b0, 1'b0);
      wait_idle(1);
    end

    repeat (4) @(negedge clk);
    chk("sb6_drained", 32'(sb6.size()), 32'd0);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
    $finish;
  end

endmodule
